// File: rtl/point_set_gen.sv
// Random 2-D point set generator: fills an internal point memory with
// xorshift32-drawn (x, y) pairs bounded to an X_MAX x Y_MAX canvas by rejection.
module point_set_gen #(
  parameter int          N_POINTS = 64,
  parameter int          ADDR_W   = 6,
  parameter int          COORD_W  = 10,
  parameter int          X_MAX    = 640,
  parameter int          Y_MAX    = 480,
  parameter logic [31:0] DEF_SEED = 32'h2463534A
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               seed_load,
  input  logic [31:0]        seed_in,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W:0]    points_valid,
  output logic [15:0]        reject_cnt,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [COORD_W-1:0] rd_x,
  output logic [COORD_W-1:0] rd_y
);

  typedef enum logic [1:0] {IDLE, GEN_X, GEN_Y, DONE} state_t;

  // Bounds widened by one bit so X_MAX/Y_MAX == 2**COORD_W stay representable.
  localparam logic [COORD_W:0]  X_LIM    = (COORD_W+1)'(X_MAX);
  localparam logic [COORD_W:0]  Y_LIM    = (COORD_W+1)'(Y_MAX);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_POINTS - 1);
  localparam logic [ADDR_W:0]   N_LIM    = (ADDR_W+1)'(N_POINTS);
  localparam logic [ADDR_W:0]   PV_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

  state_t              state;
  logic [31:0]         rng;
  logic [31:0]         rng_next;
  logic [ADDR_W-1:0]   idx;
  logic [COORD_W-1:0]  x_hold;
  logic [COORD_W-1:0]  d;
  logic                x_ok;
  logic                y_ok;
  logic                wr_en;
  logic                rd_in_range;

  logic [COORD_W-1:0]  mem_x [N_POINTS];
  logic [COORD_W-1:0]  mem_y [N_POINTS];

  always_comb begin
    rng_next = rng;
    rng_next = rng_next ^ (rng_next << 13);
    rng_next = rng_next ^ (rng_next >> 17);
    rng_next = rng_next ^ (rng_next << 5);
  end

  assign d           = rng_next[COORD_W-1:0];
  assign x_ok        = {1'b0, d} < X_LIM;
  assign y_ok        = {1'b0, d} < Y_LIM;
  assign wr_en       = (state == GEN_Y) && y_ok;
  assign rd_in_range = {1'b0, rd_addr} < N_LIM;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      rng          <= DEF_SEED;
      idx          <= '0;
      x_hold       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      points_valid <= '0;
      reject_cnt   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            if (seed_load) rng <= (seed_in == 32'd0) ? DEF_SEED : seed_in;
            idx          <= '0;
            points_valid <= '0;
            reject_cnt   <= '0;
            done         <= 1'b0;
            busy         <= 1'b1;
            state        <= GEN_X;
          end
        end
        GEN_X: begin
          rng <= rng_next;
          if (x_ok) begin
            x_hold <= d;
            state  <= GEN_Y;
          end else if (reject_cnt != 16'hFFFF) begin
            reject_cnt <= reject_cnt + 16'd1;
          end
        end
        GEN_Y: begin
          rng <= rng_next;
          if (y_ok) begin
            points_valid <= {1'b0, idx} + PV_ONE;
            if (idx == LAST_IDX) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              idx   <= idx + IDX_ONE;
              state <= GEN_X;
            end
          end else if (reject_cnt != 16'hFFFF) begin
            reject_cnt <= reject_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Point memory is deliberately left out of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_x[idx] <= x_hold;
      mem_y[idx] <= d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_x <= '0;
      rd_y <= '0;
    end else begin
      rd_x <= rd_in_range ? mem_x[rd_addr] : '0;
      rd_y <= rd_in_range ? mem_y[rd_addr] : '0;
    end
  end

endmodule

// File: tb/tb_point_set_gen.sv
// Bench for point_set_gen: three builds (640x480, 100x100 with ADDR_W=7, 1024x1024)
// driven in lockstep and checked against a plain xorshift32 rejection-sampling model.
module tb_point_set_gen;

  localparam logic [31:0] DEF = 32'h2463534A;
  localparam int NP = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        seed_load = 1'b0;
  logic [31:0] seed_in = 32'd0;
  logic [6:0]  rd_addr = 7'd0;

  logic        busy_o [3];
  logic        done_o [3];
  logic [15:0] rej_o  [3];
  logic [9:0]  rd_x_o [3];
  logic [9:0]  rd_y_o [3];
  logic [6:0]  pv_a, pv_c;
  logic [7:0]  pv_b;
  logic [7:0]  pv_o   [3];

  always #5 clk = ~clk;

  always_comb begin
    pv_o[0] = {1'b0, pv_a};
    pv_o[1] = pv_b;
    pv_o[2] = {1'b0, pv_c};
  end

  point_set_gen dut_a (
    .clk(clk), .rst(rst), .start(start), .seed_load(seed_load), .seed_in(seed_in),
    .busy(busy_o[0]), .done(done_o[0]), .points_valid(pv_a), .reject_cnt(rej_o[0]),
    .rd_addr(rd_addr[5:0]), .rd_x(rd_x_o[0]), .rd_y(rd_y_o[0]));

  point_set_gen #(.ADDR_W(7), .X_MAX(100), .Y_MAX(100)) dut_b (
    .clk(clk), .rst(rst), .start(start), .seed_load(seed_load), .seed_in(seed_in),
    .busy(busy_o[1]), .done(done_o[1]), .points_valid(pv_b), .reject_cnt(rej_o[1]),
    .rd_addr(rd_addr), .rd_x(rd_x_o[1]), .rd_y(rd_y_o[1]));

  point_set_gen #(.X_MAX(1024), .Y_MAX(1024)) dut_c (
    .clk(clk), .rst(rst), .start(start), .seed_load(seed_load), .seed_in(seed_in),
    .busy(busy_o[2]), .done(done_o[2]), .points_valid(pv_c), .reject_cnt(rej_o[2]),
    .rd_addr(rd_addr[5:0]), .rd_x(rd_x_o[2]), .rd_y(rd_y_o[2]));

  int n_cmp = 0;
  int n_bad = 0;

  int          xm [3] = '{640, 100, 1024};
  int          ym [3] = '{480, 100, 1024};
  logic [31:0] mrng [3];
  logic [9:0]  exp_x [3][NP];
  logic [9:0]  exp_y [3][NP];
  logic [15:0] exp_rej [3];
  int          exp_cyc [3];

  int          obs_cyc [3];
  logic        obs_busy1 [3];
  logic        obs_busy [3];
  logic        obs_done [3];
  logic [15:0] obs_rej [3];
  logic [7:0]  obs_pv [3];
  logic [9:0]  obs_x [3][NP];
  logic [9:0]  obs_y [3][NP];

  function automatic logic [31:0] xs32(input logic [31:0] v);
    logic [31:0] t;
    t = v;
    t = t ^ (t << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  // Draw until in range, counting every discarded draw; x then y per point.
  task automatic model_run(input int k);
    logic [31:0] r;
    int rej;
    r = mrng[k];
    rej = 0;
    for (int n = 0; n < NP; n++) begin
      r = xs32(r);
      while (int'(r[9:0]) >= xm[k]) begin rej++; r = xs32(r); end
      exp_x[k][n] = r[9:0];
      r = xs32(r);
      while (int'(r[9:0]) >= ym[k]) begin rej++; r = xs32(r); end
      exp_y[k][n] = r[9:0];
    end
    mrng[k]    = r;
    exp_rej[k] = (rej > 65535) ? 16'hFFFF : 16'(rej);
    exp_cyc[k] = 2 * NP + rej;
  endtask

  // Drives one run (optionally with a stray start on edge inj), then reads back all points.
  task automatic do_run(input bit load, input logic [31:0] seed, input int inj);
    bit all_done;
    if (load) for (int k = 0; k < 3; k++) mrng[k] = (seed == 32'd0) ? DEF : seed;
    for (int k = 0; k < 3; k++) model_run(k);
    @(negedge clk);
    start = 1'b1; seed_load = load; seed_in = seed;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin obs_busy1[k] = busy_o[k]; obs_cyc[k] = -1; end
    all_done = 1'b0;
    for (int i = 1; i <= 4000 && !all_done; i++) begin
      if (i == inj) begin
        @(negedge clk);
        start = 1'b1; seed_load = 1'b1; seed_in = $urandom;
      end
      @(posedge clk); #1;
      start = 1'b0;
      all_done = 1'b1;
      for (int k = 0; k < 3; k++) begin
        if (obs_cyc[k] < 0 && done_o[k] === 1'b1) obs_cyc[k] = i;
        if (obs_cyc[k] < 0) all_done = 1'b0;
      end
    end
    for (int k = 0; k < 3; k++) begin
      obs_busy[k] = busy_o[k]; obs_done[k] = done_o[k];
      obs_rej[k] = rej_o[k]; obs_pv[k] = pv_o[k];
    end
    for (int a = 0; a < NP; a++) begin
      @(negedge clk); rd_addr = 7'(a);
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin obs_x[k][a] = rd_x_o[k]; obs_y[k][a] = rd_y_o[k]; end
    end
    $display("run load=%0d seed=%08h: cycles %0d/%0d/%0d rejects %0d/%0d/%0d", load, seed,
             obs_cyc[0], obs_cyc[1], obs_cyc[2], obs_rej[0], obs_rej[1], obs_rej[2]);
  endtask

  task automatic test_reset;
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if ({busy_o[k], done_o[k], pv_o[k], rej_o[k], rd_x_o[k], rd_y_o[k]} !== '0) begin
        n_bad++;
        $display("FAIL reset dut%0d: busy=%b done=%b pv=%0d rej=%0d x=%0d y=%0d, want all 0",
                 k, busy_o[k], done_o[k], pv_o[k], rej_o[k], rd_x_o[k], rd_y_o[k]);
      end
    end
    for (int k = 0; k < 3; k++) mrng[k] = DEF;
    @(negedge clk); rst = 1'b0;
    $display("reset checked");
  endtask

  task automatic test_seed_one;
    bit in_box;
    do_run(1'b1, 32'd1, 0);
    n_cmp++;
    if (obs_x[0][0] !== 10'd33) begin
      n_bad++; $display("FAIL seed1 first_x: got %0d want 33", obs_x[0][0]);
    end
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (obs_busy1[k] !== 1'b1) begin
        n_bad++; $display("FAIL seed1 busy_after_start dut%0d: got %b want 1", k, obs_busy1[k]);
      end
      n_cmp++;
      if (obs_cyc[k] !== exp_cyc[k]) begin
        n_bad++; $display("FAIL seed1 done_cycle dut%0d: got %0d want %0d", k, obs_cyc[k], exp_cyc[k]);
      end
      n_cmp++;
      if (obs_rej[k] !== exp_rej[k] || obs_pv[k] !== 8'(NP) || obs_busy[k] !== 1'b0 || obs_done[k] !== 1'b1) begin
        n_bad++; $display("FAIL seed1 status dut%0d: rej=%0d pv=%0d busy=%b done=%b want rej=%0d pv=64 busy=0 done=1",
                          k, obs_rej[k], obs_pv[k], obs_busy[k], obs_done[k], exp_rej[k]);
      end
      for (int a = 0; a < NP; a++) begin
        n_cmp++;
        if (obs_x[k][a] !== exp_x[k][a] || obs_y[k][a] !== exp_y[k][a]) begin
          n_bad++; $display("FAIL seed1 point dut%0d[%0d]: got (%0d,%0d) want (%0d,%0d)",
                            k, a, obs_x[k][a], obs_y[k][a], exp_x[k][a], exp_y[k][a]);
        end
      end
    end
    in_box = 1'b1;
    for (int a = 0; a < NP; a++) if (obs_x[1][a] >= 10'd100 || obs_y[1][a] >= 10'd100) in_box = 1'b0;
    n_cmp++;
    if (!in_box || obs_rej[1] == 16'd0) begin
      n_bad++; $display("FAIL small_canvas: in_box=%b rej=%0d want in_box=1 rej>0", in_box, obs_rej[1]);
    end
    n_cmp++;
    if (obs_rej[2] !== 16'd0 || obs_cyc[2] !== 2 * NP) begin
      n_bad++; $display("FAIL full_canvas: rej=%0d cycles=%0d want rej=0 cycles=128", obs_rej[2], obs_cyc[2]);
    end
  endtask

  task automatic test_zero_seed;
    do_run(1'b1, 32'd0, 0);
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (obs_cyc[k] !== exp_cyc[k] || obs_rej[k] !== exp_rej[k] || obs_pv[k] !== 8'(NP)) begin
        n_bad++; $display("FAIL zero_seed status dut%0d: cycles=%0d rej=%0d pv=%0d want %0d/%0d/64",
                          k, obs_cyc[k], obs_rej[k], obs_pv[k], exp_cyc[k], exp_rej[k]);
      end
      for (int a = 0; a < NP; a++) begin
        n_cmp++;
        if (obs_x[k][a] !== exp_x[k][a] || obs_y[k][a] !== exp_y[k][a]) begin
          n_bad++; $display("FAIL zero_seed point dut%0d[%0d]: got (%0d,%0d) want (%0d,%0d)",
                            k, a, obs_x[k][a], obs_y[k][a], exp_x[k][a], exp_y[k][a]);
        end
      end
    end
  endtask

  task automatic test_continue;
    do_run(1'b0, $urandom, 0);
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (obs_cyc[k] !== exp_cyc[k] || obs_rej[k] !== exp_rej[k] || obs_pv[k] !== 8'(NP)) begin
        n_bad++; $display("FAIL continue status dut%0d: cycles=%0d rej=%0d pv=%0d want %0d/%0d/64",
                          k, obs_cyc[k], obs_rej[k], obs_pv[k], exp_cyc[k], exp_rej[k]);
      end
      for (int a = 0; a < NP; a++) begin
        n_cmp++;
        if (obs_x[k][a] !== exp_x[k][a] || obs_y[k][a] !== exp_y[k][a]) begin
          n_bad++; $display("FAIL continue point dut%0d[%0d]: got (%0d,%0d) want (%0d,%0d)",
                            k, a, obs_x[k][a], obs_y[k][a], exp_x[k][a], exp_y[k][a]);
        end
      end
    end
  endtask

  task automatic test_busy_start;
    do_run(1'b1, $urandom | 32'd1, 10);
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (obs_cyc[k] !== exp_cyc[k] || obs_rej[k] !== exp_rej[k]) begin
        n_bad++; $display("FAIL busy_start status dut%0d: cycles=%0d rej=%0d want %0d/%0d",
                          k, obs_cyc[k], obs_rej[k], exp_cyc[k], exp_rej[k]);
      end
      for (int a = 0; a < NP; a++) begin
        n_cmp++;
        if (obs_x[k][a] !== exp_x[k][a] || obs_y[k][a] !== exp_y[k][a]) begin
          n_bad++; $display("FAIL busy_start point dut%0d[%0d]: got (%0d,%0d) want (%0d,%0d)",
                            k, a, obs_x[k][a], obs_y[k][a], exp_x[k][a], exp_y[k][a]);
        end
      end
    end
  endtask

  task automatic test_mid_reset;
    @(negedge clk);
    start = 1'b1; seed_load = 1'b1; seed_in = $urandom;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if ({busy_o[k], done_o[k], pv_o[k], rej_o[k], rd_x_o[k], rd_y_o[k]} !== '0) begin
        n_bad++;
        $display("FAIL mid_reset dut%0d: busy=%b done=%b pv=%0d rej=%0d x=%0d y=%0d, want all 0",
                 k, busy_o[k], done_o[k], pv_o[k], rej_o[k], rd_x_o[k], rd_y_o[k]);
      end
    end
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 3; k++) mrng[k] = DEF;
    do_run(1'b0, 32'd0, 0);
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (obs_cyc[k] !== exp_cyc[k] || obs_rej[k] !== exp_rej[k] || obs_pv[k] !== 8'(NP)) begin
        n_bad++; $display("FAIL after_reset status dut%0d: cycles=%0d rej=%0d pv=%0d want %0d/%0d/64",
                          k, obs_cyc[k], obs_rej[k], obs_pv[k], exp_cyc[k], exp_rej[k]);
      end
      for (int a = 0; a < NP; a++) begin
        n_cmp++;
        if (obs_x[k][a] !== exp_x[k][a] || obs_y[k][a] !== exp_y[k][a]) begin
          n_bad++; $display("FAIL after_reset point dut%0d[%0d]: got (%0d,%0d) want (%0d,%0d)",
                            k, a, obs_x[k][a], obs_y[k][a], exp_x[k][a], exp_y[k][a]);
        end
      end
    end
  endtask

  task automatic test_out_of_range;
    int addr;
    for (int i = 0; i < 6; i++) begin
      addr = (i == 0) ? 64 : (i == 1) ? 127 : int'($urandom_range(127, 65));
      @(negedge clk); rd_addr = 7'(addr);
      @(posedge clk); #1;
      n_cmp++;
      if (rd_x_o[1] !== 10'd0 || rd_y_o[1] !== 10'd0) begin
        n_bad++; $display("FAIL out_of_range addr %0d: got (%0d,%0d) want (0,0)", addr, rd_x_o[1], rd_y_o[1]);
      end
      $display("read addr %0d -> (%0d,%0d)", addr, rd_x_o[1], rd_y_o[1]);
    end
  endtask

  initial begin
    test_reset();
    test_seed_one();
    test_zero_seed();
    test_continue();
    test_busy_start();
    test_mid_reset();
    test_out_of_range();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
